// File: rtl/pmul_row.sv
// pmul_row: TAPS-stage signed multiply-accumulate row with round/shift, saturation,
// optional ReLU and valid/ready backpressure. One dot product per accepted beat.
module pmul_row #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAPS      = 3,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TAPS*WIDTH-1:0]     in_data,
  input  logic [TAPS*WIDTH-1:0]     in_weight,
  input  logic [ACC_WIDTH-1:0]      in_bias,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic                      relu_en,
  output logic [OUT_WIDTH-1:0]      psum,
  output logic                      psum_sat,
  output logic                      psum_vld,
  input  logic                      psum_rdy
);

  // Half-LSB rounding constant; evaluates to 0 when SHIFT is 0.
  localparam logic [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [ACC_WIDTH:0] MAXV =
      (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  // Whole pipeline advances together; it only freezes when a result is stuck at the output.
  logic w_en;
  assign w_en   = ~psum_vld | psum_rdy;
  assign in_rdy = w_en;

  // Input register: the accepted beat with all its operands.
  logic                  r_in_v;
  logic                  r_in_relu;
  logic [TAPS*WIDTH-1:0] r_in_data;
  logic [TAPS*WIDTH-1:0] r_in_weight;
  logic [ACC_WIDTH-1:0]  r_in_bias;

  // Capture the beat on every enabled cycle; bubbles carry r_in_v = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_v      <= 1'b0;
      r_in_relu   <= 1'b0;
      r_in_data   <= '0;
      r_in_weight <= '0;
      r_in_bias   <= '0;
    end else if (w_en) begin
      r_in_v      <= in_vld;
      r_in_relu   <= relu_en;
      r_in_data   <= in_data;
      r_in_weight <= in_weight;
      r_in_bias   <= in_bias;
    end
  end

  // Per-tap operands aligned to their stage, and sign-extended products.
  logic [TAPS-1:0][WIDTH-1:0]     w_d;
  logic [TAPS-1:0][WIDTH-1:0]     w_w;
  logic [TAPS-1:0][ACC_WIDTH-1:0] w_prod_x;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [2*WIDTH-1:0] w_prod;

    if (k == 0) begin : g_direct
      assign w_d[k] = r_in_data[0 +: WIDTH];
      assign w_w[k] = r_in_weight[0 +: WIDTH];
    end else begin : g_skew
      logic [WIDTH-1:0] r_sd [k];
      logic [WIDTH-1:0] r_sw [k];

      // Delay tap k by k cycles so it meets its beat's partial sum at stage k.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            r_sd[j] <= '0;
            r_sw[j] <= '0;
          end
        end else if (w_en) begin
          r_sd[0] <= r_in_data[k*WIDTH +: WIDTH];
          r_sw[0] <= r_in_weight[k*WIDTH +: WIDTH];
          for (int j = 1; j < k; j++) begin
            r_sd[j] <= r_sd[j-1];
            r_sw[j] <= r_sw[j-1];
          end
        end
      end

      assign w_d[k] = r_sd[k-1];
      assign w_w[k] = r_sw[k-1];
    end

    assign w_prod      = $signed(w_d[k]) * $signed(w_w[k]);
    assign w_prod_x[k] = ACC_WIDTH'(w_prod);
  end

  // MAC stages.
  logic [TAPS-1:0]                r_v;
  logic [TAPS-1:0]                r_relu;
  logic [TAPS-1:0][ACC_WIDTH-1:0] r_p;

  // Accumulate one tap per stage; sums wrap modulo 2^ACC_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_relu <= '0;
      r_p    <= '0;
    end else if (w_en) begin
      r_v[0]    <= r_in_v;
      r_relu[0] <= r_in_relu;
      r_p[0]    <= r_in_bias + w_prod_x[0];
      for (int k = 1; k < TAPS; k++) begin
        r_v[k]    <= r_v[k-1];
        r_relu[k] <= r_relu[k-1];
        r_p[k]    <= r_p[k-1] + w_prod_x[k];
      end
    end
  end

  // Round, shift, clamp and ReLU on the final partial sum.
  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_shr;
  logic [OUT_WIDTH-1:0]      w_clamp;
  logic [OUT_WIDTH-1:0]      w_out;
  logic                      w_sat;

  assign w_sum = $signed({r_p[TAPS-1][ACC_WIDTH-1], r_p[TAPS-1]}) + $signed(RND);
  assign w_shr = w_sum >>> SHIFT;

  // Saturate to the output range and apply ReLU after the clamp.
  always_comb begin
    w_sat   = 1'b0;
    w_clamp = w_shr[OUT_WIDTH-1:0];
    if (w_shr > MAXV) begin
      w_sat   = 1'b1;
      w_clamp = MAXV[OUT_WIDTH-1:0];
    end else if (w_shr < MINV) begin
      w_sat   = 1'b1;
      w_clamp = MINV[OUT_WIDTH-1:0];
    end
    w_out = (r_relu[TAPS-1] && w_clamp[OUT_WIDTH-1]) ? '0 : w_clamp;
  end

  // Output register; holds while the consumer is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_vld <= 1'b0;
      psum_sat <= 1'b0;
      psum     <= '0;
    end else if (w_en) begin
      psum_vld <= r_v[TAPS-1];
      psum_sat <= w_sat;
      psum     <= w_out;
    end
  end

endmodule

// File: tb/tb_pmul_row.sv
// Directed bench for pmul_row: table of single beats plus stream, stall and reset sequences.
module tb_pmul_row;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] in_data, in_weight;
  logic [19:0] in_bias;
  logic        in_vld, relu_en, psum_rdy;
  logic        in_rdy, psum_sat, psum_vld;
  logic signed [7:0] psum;
  logic        in_rdy_s2, psum_sat_s2, psum_vld_s2;
  logic signed [7:0] psum_s2;

  pmul_row #(.WIDTH(8), .TAPS(3), .ACC_WIDTH(20), .OUT_WIDTH(8), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
    .in_vld(in_vld), .in_rdy(in_rdy), .relu_en(relu_en), .psum(psum),
    .psum_sat(psum_sat), .psum_vld(psum_vld), .psum_rdy(psum_rdy)
  );

  pmul_row #(.WIDTH(8), .TAPS(3), .ACC_WIDTH(20), .OUT_WIDTH(8), .SHIFT(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
    .in_vld(in_vld), .in_rdy(in_rdy_s2), .relu_en(relu_en), .psum(psum_s2),
    .psum_sat(psum_sat_s2), .psum_vld(psum_vld_s2), .psum_rdy(psum_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [23:0] mk3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  typedef struct {
    string       name;
    logic [23:0] data;
    logic [23:0] weight;
    int          bias;
    bit          relu;
    int          exp;
    bit          exp_sat;
    int          exp_s2;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one isolated beat and check its result, latency and single-cycle valid.
  task automatic run_beat(input vec_t v);
    int lat;
    psum_rdy  = 1'b1;
    in_data   = v.data;
    in_weight = v.weight;
    in_bias   = 20'(v.bias);
    relu_en   = v.relu;
    in_vld    = 1'b1;
    chk({v.name, "_in_rdy"}, int'(in_rdy), 1);
    step();
    in_vld = 1'b0;
    lat = 0;
    while (!psum_vld && lat < 12) begin
      step();
      lat++;
    end
    chk({v.name, "_latency"}, lat, 4);
    chk({v.name, "_psum"}, int'(psum), v.exp);
    chk({v.name, "_sat"}, int'(psum_sat), int'(v.exp_sat));
    chk({v.name, "_psum_s2"}, int'(psum_s2), v.exp_s2);
    step();
    chk({v.name, "_vld_drop"}, int'(psum_vld), 0);
  endtask

  int   lat, sent, recv, cyc, stale;
  bit   stall_prev;
  int   held;
  vec_t nb;

  initial begin
    vecs[0] = '{"dot", mk3(1, 2, 3), mk3(4, 5, 6), 0, 1'b0, 32, 1'b0, 8};
    vecs[1] = '{"sat_pos", mk3(127, 127, 127), mk3(127, 127, 127), 0, 1'b0, 127, 1'b1, 127};
    vecs[2] = '{"sat_neg", mk3(-128, -128, -128), mk3(127, 127, 127), 0, 1'b0, -128, 1'b1,
                -128};
    vecs[3] = '{"sat_neg_relu", mk3(-128, -128, -128), mk3(127, 127, 127), 0, 1'b1, 0, 1'b1,
                0};
    vecs[4] = '{"relu_small", mk3(-1, 0, 0), mk3(1, 0, 0), 0, 1'b1, 0, 1'b0, 0};
    vecs[5] = '{"rnd_p10", mk3(0, 0, 0), mk3(0, 0, 0), 10, 1'b0, 10, 1'b0, 3};
    vecs[6] = '{"rnd_m10", mk3(0, 0, 0), mk3(0, 0, 0), -10, 1'b0, -10, 1'b0, -2};
    vecs[7] = '{"rnd_p6", mk3(0, 0, 0), mk3(0, 0, 0), 6, 1'b0, 6, 1'b0, 2};
    vecs[8] = '{"mixed", mk3(-3, 4, 5), mk3(7, -2, 1), 100, 1'b0, 76, 1'b0, 19};

    rst = 1'b1; in_data = '0; in_weight = '0; in_bias = '0;
    in_vld = 1'b0; relu_en = 1'b0; psum_rdy = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("reset_vld", int'(psum_vld), 0);
    chk("reset_psum", int'(psum), 0);
    chk("reset_sat", int'(psum_sat), 0);
    chk("reset_in_rdy", int'(in_rdy), 1);

    foreach (vecs[i]) run_beat(vecs[i]);

    // Back-to-back beats, bias 5, unit weights.
    in_weight = mk3(1, 1, 1); in_bias = 20'd5; relu_en = 1'b0; in_vld = 1'b1;
    in_data = mk3(1, 1, 1);   step();
    in_data = mk3(2, 2, 2);   step();
    in_data = mk3(-1, 0, 1);  step();
    in_vld = 1'b0;
    lat = 2;
    while (!psum_vld && lat < 12) begin
      step();
      lat++;
    end
    chk("b2b_latency", lat, 4);
    chk("b2b_psum0", int'(psum), 8);
    step();
    chk("b2b_vld1", int'(psum_vld), 1);
    chk("b2b_psum1", int'(psum), 11);
    step();
    chk("b2b_vld2", int'(psum_vld), 1);
    chk("b2b_psum2", int'(psum), 5);
    step();
    chk("b2b_vld_drop", int'(psum_vld), 0);

    // Ten-beat stream with a five-cycle consumer stall.
    in_data = '0; in_weight = '0;
    sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0; held = 0;
    while (recv < 10 && cyc < 60) begin
      psum_rdy = !(cyc >= 6 && cyc < 11);
      in_vld   = (sent < 10);
      in_bias  = 20'(sent);
      #1;
      if (stall_prev) begin
        chk("stall_hold_psum", int'(psum), held);
        chk("stall_hold_vld", int'(psum_vld), 1);
      end
      if (psum_vld && !psum_rdy) begin
        chk("stall_in_rdy", int'(in_rdy), 0);
        held = int'(psum);
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (psum_vld && psum_rdy) begin
        chk("stream_order", int'(psum), recv);
        recv++;
      end
      if (in_vld && in_rdy) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stream_recv", recv, 10);
    chk("stream_sent", sent, 10);
    in_vld = 1'b0; psum_rdy = 1'b1;
    step();

    // Reset with three beats in flight and a beat offered during reset.
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_bias = 20'(50 + i);
      step();
    end
    rst = 1'b1; in_bias = 20'd53;
    step();
    rst = 1'b0; in_vld = 1'b0;
    chk("rst_mid_vld", int'(psum_vld), 0);
    chk("rst_mid_in_rdy", int'(in_rdy), 1);
    stale = 0;
    repeat (8) begin
      if (psum_vld) stale++;
      step();
    end
    chk("rst_mid_stale", stale, 0);
    nb = '{"post_rst", mk3(0, 0, 0), mk3(0, 0, 0), 7, 1'b0, 7, 1'b0, 2};
    run_beat(nb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
